// File: rtl/sparc_decode_stage_if.sv
// sparc_decode_stage_if: fetch/preload controls and decoded ID-stage outputs
interface sparc_decode_stage_if #(parameter int ADDR_W = 8);
  logic [ADDR_W-1:0] pc;
  logic              LE;
  logic              S;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [31:0]       if_instr;
  logic [31:0]       id_instr;
  logic [1:0]        ID_op;
  logic [5:0]        ID_ALU_op3;
  logic              ID_jmpl_instr;
  logic              ID_Read_Write;
  logic              ID_SE_dm;
  logic              ID_load_instr;
  logic              ID_RF_enable;
  logic [1:0]        ID_size_dm;
  logic              ID_modifyCC;
  logic              ID_Call_instr;
  logic              ID_B_instr;
  logic              ID_29_a;
  modport master (
    output pc, LE, S, wr_en, wr_addr, wr_data,
    input  if_instr, id_instr, ID_op, ID_ALU_op3, ID_jmpl_instr, ID_Read_Write, ID_SE_dm,
           ID_load_instr, ID_RF_enable, ID_size_dm, ID_modifyCC, ID_Call_instr, ID_B_instr, ID_29_a
  );
  modport slave (
    input  pc, LE, S, wr_en, wr_addr, wr_data,
    output if_instr, id_instr, ID_op, ID_ALU_op3, ID_jmpl_instr, ID_Read_Write, ID_SE_dm,
           ID_load_instr, ID_RF_enable, ID_size_dm, ID_modifyCC, ID_Call_instr, ID_B_instr, ID_29_a
  );
endinterface

// File: rtl/sparc_decode_stage.sv
// sparc_decode_stage: byte instruction memory, IF/ID register and ID control decode with bubble mux
module sparc_decode_stage #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W    = 8
) (
  input logic Clk,
  input logic R,
  sparc_decode_stage_if.slave bus
);
  logic [7:0]        mem [MEM_DEPTH];
  logic [31:0]       ir;
  logic [ADDR_W-1:0] a1, a2, a3;
  logic [1:0]        op;
  logic [2:0]        op2;
  logic [5:0]        op3;
  logic [5:0]        alu;
  logic [1:0]        sz;
  logic              jmpl, rw, se, ld, rf, mcc, call, br, ann;
  always_ff @(posedge Clk)
    if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
  // address increments wrap naturally in ADDR_W bits
  assign a1 = bus.pc + ADDR_W'(1);
  assign a2 = bus.pc + ADDR_W'(2);
  assign a3 = bus.pc + ADDR_W'(3);
  assign bus.if_instr = {mem[bus.pc], mem[a1], mem[a2], mem[a3]};
  always_ff @(posedge Clk or negedge R)
    if (!R) ir <= '0;
    else if (bus.LE) ir <= bus.if_instr;
  assign bus.id_instr = ir;
  assign op  = ir[31:30];
  assign op2 = ir[24:22];
  assign op3 = ir[24:19];
  always_comb begin
    alu  = '0;
    sz   = '0;
    jmpl = 1'b0;
    rw   = 1'b0;
    se   = 1'b0;
    ld   = 1'b0;
    rf   = 1'b0;
    mcc  = 1'b0;
    call = 1'b0;
    br   = 1'b0;
    ann  = 1'b0;
    case (op)
      2'b01: begin
        call = 1'b1;
        rf   = 1'b1;
      end
      2'b00: begin
        br  = op2 == 3'b010;
        ann = op2 == 3'b010 && ir[29];
        rf  = op2 == 3'b100;
        alu = op2 == 3'b100 ? 6'b001110 : 6'b000000;
      end
      2'b10: begin
        jmpl = op3 == 6'b111000;
        rf   = 1'b1;
        alu  = op3 == 6'b111000 ? 6'b000000 : op3;
        mcc  = op3 != 6'b111000 && op3[4] && !op3[5];
      end
      default: begin
        sz = op3[1:0] == 2'b01 ? 2'b00 : op3[1:0] == 2'b10 ? 2'b01 : 2'b10;
        rw = op3[2];
        ld = !op3[2];
        rf = !op3[2];
        se = !op3[2] && op3[3];
      end
    endcase
  end
  // ID_op bypasses the bubble so downstream format checks still see the instruction class
  assign bus.ID_op         = op;
  assign bus.ID_ALU_op3    = bus.S ? 6'b0 : alu;
  assign bus.ID_jmpl_instr = !bus.S && jmpl;
  assign bus.ID_Read_Write = !bus.S && rw;
  assign bus.ID_SE_dm      = !bus.S && se;
  assign bus.ID_load_instr = !bus.S && ld;
  assign bus.ID_RF_enable  = !bus.S && rf;
  assign bus.ID_size_dm    = bus.S ? 2'b0 : sz;
  assign bus.ID_modifyCC   = !bus.S && mcc;
  assign bus.ID_Call_instr = !bus.S && call;
  assign bus.ID_B_instr    = !bus.S && br;
  assign bus.ID_29_a       = !bus.S && ann;
endmodule

// File: tb/tb_sparc_decode_stage.sv
// tb_sparc_decode_stage: directed vectors, expectations queued and checked by a negedge monitor
module tb_sparc_decode_stage;
  typedef struct {
    string       name;
    bit          kind;
    logic [63:0] val;
  } exp_t;
  logic Clk, R;
  exp_t q[$];
  int   n_cmp = 0, n_err = 0;
  sparc_decode_stage_if #(.ADDR_W(8)) bus ();
  sparc_decode_stage #(.MEM_DEPTH(256), .ADDR_W(8)) dut (.Clk(Clk), .R(R), .bus(bus));
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  // f = {jmpl, rw, se, ld, rf, mcc, call, b, a}
  function automatic logic [63:0] ev(logic [31:0] ir, logic [5:0] alu, logic [1:0] sz, logic [8:0] f);
    return {13'b0, ir, ir[31:30], alu, f[8:4], sz, f[3:0]};
  endfunction
  function automatic logic [63:0] act();
    return {13'b0, bus.id_instr, bus.ID_op, bus.ID_ALU_op3, bus.ID_jmpl_instr, bus.ID_Read_Write,
            bus.ID_SE_dm, bus.ID_load_instr, bus.ID_RF_enable, bus.ID_size_dm, bus.ID_modifyCC,
            bus.ID_Call_instr, bus.ID_B_instr, bus.ID_29_a};
  endfunction
  initial forever begin
    @(negedge Clk);
    while (q.size() > 0) begin
      exp_t e;
      logic [63:0] a;
      e = q.pop_front();
      a = e.kind ? {32'b0, bus.if_instr} : act();
      n_cmp++;
      if (a !== e.val) begin
        n_err++;
        $display("FAIL %s: got %h want %h", e.name, a, e.val);
      end
    end
  end
  task automatic chk(string name, bit kind, logic [63:0] val);
    q.push_back('{name, kind, val});
    @(negedge Clk);
    #1;
  endtask
  task automatic wr(logic [7:0] a, logic [7:0] d);
    bus.wr_en = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    @(posedge Clk);
    #1;
    bus.wr_en = 1'b0;
  endtask
  task automatic wr_word(logic [7:0] a, logic [31:0] w);
    wr(a, w[31:24]);
    wr(a + 8'd1, w[23:16]);
    wr(a + 8'd2, w[15:8]);
    wr(a + 8'd3, w[7:0]);
  endtask
  task automatic fetch(logic [7:0] a);
    bus.pc = a;
    bus.LE = 1'b1;
    @(posedge Clk);
    #1;
    bus.LE = 1'b0;
  endtask
  task automatic run(string name, logic [7:0] a, logic [31:0] w, logic [5:0] alu, logic [1:0] sz, logic [8:0] f);
    wr_word(a, w);
    fetch(a);
    chk(name, 1'b0, ev(w, alu, sz, f));
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
  initial begin
    R = 1'b0;
    bus.pc = '0;
    bus.LE = 1'b0;
    bus.S = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    repeat (2) @(posedge Clk);
    #1;
    chk("reset", 1'b0, ev(32'h0, 6'b0, 2'b00, 9'b0));
    R = 1'b1;
    run("nop", 8'd0, 32'h0000_0000, 6'b000000, 2'b00, 9'b000000000);
    run("addcc", 8'd0, 32'h8680_4002, 6'b010000, 2'b00, 9'b000011000);
    bus.S = 1'b1;
    chk("addcc_bubble", 1'b0, ev(32'h8680_4002, 6'b0, 2'b00, 9'b0));
    bus.S = 1'b0;
    run("ldsb", 8'd4, 32'hC648_A000, 6'b000000, 2'b00, 9'b001110000);
    run("stb", 8'd8, 32'hC428_4000, 6'b000000, 2'b00, 9'b010000000);
    run("ld", 8'd12, 32'hC200_6000, 6'b000000, 2'b10, 9'b000110000);
    run("call", 8'd16, 32'h4000_0004, 6'b000000, 2'b00, 9'b000010100);
    run("bicc_a", 8'd20, 32'h2280_0002, 6'b000000, 2'b00, 9'b000000011);
    run("sethi", 8'd24, 32'h0300_0010, 6'b001110, 2'b00, 9'b000010000);
    run("jmpl", 8'd28, 32'h81C3_E008, 6'b000000, 2'b00, 9'b100010000);
    bus.pc = 8'd4;
    repeat (3) @(posedge Clk);
    #1;
    chk("hold", 1'b0, ev(32'h81C3_E008, 6'b000000, 2'b00, 9'b100010000));
    wr(8'd255, 8'hAA);
    wr(8'd0, 8'hBB);
    wr(8'd1, 8'hCC);
    wr(8'd2, 8'hDD);
    bus.pc = 8'd255;
    chk("wrap_if", 1'b1, 64'h0000_0000_AABB_CCDD);
    fetch(8'd255);
    chk("wrap_decode", 1'b0, ev(32'hAABB_CCDD, 6'b010111, 2'b00, 9'b000011000));
    @(posedge Clk);
    #2;
    R = 1'b0;
    chk("async_reset", 1'b0, ev(32'h0, 6'b0, 2'b00, 9'b0));
    @(negedge Clk);
    if (q.size() > 0) begin
      n_err += q.size();
      $display("FAIL leftover: got %0d unchecked want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sparc_decode_stage.md
Name: sparc_decode_stage

Overview:
- Fetch-to-decode slice of the 5-stage SPARC pipeline.
- Holds a 256-byte instruction memory and reads a big-endian 32-bit word at the PC address.
- Latches that word into an IF/ID instruction register, then decodes it combinationally into ID-stage control signals.
- A bubble mux forces every control signal to zero on hazard insertion. Outputs feed the ID/EX pipeline register.

Parameters:
- MEM_DEPTH, 256, instruction memory size in bytes; must equal 2^ADDR_W.
- ADDR_W, 8, PC/address width.

Ports:
- Clk  in  1  system clock; rising edge active.
- R  in  1  asynchronous active-low reset.
- pc  in  ADDR_W  fetch byte address.
- LE  in  1  instruction-register load enable.
- S  in  1  bubble select: 0 = pass decoded controls, 1 = force all controls to zero.
- wr_en  in  1  preload write enable.
- wr_addr  in  ADDR_W  preload byte address.
- wr_data  in  8  preload byte.
- if_instr  out  32  combinational memory read at pc.
- id_instr  out  32  IF/ID instruction register.
- ID_op  out  2  id_instr[31:30]; unmuxed.
- ID_ALU_op3  out  6  ALU operation (muxed).
- ID_jmpl_instr  out  1  JMPL (muxed).
- ID_Read_Write  out  1  1 = data-memory write/store (muxed).
- ID_SE_dm  out  1  sign-extend load data (muxed).
- ID_load_instr  out  1  load (muxed).
- ID_RF_enable  out  1  register-file write (muxed).
- ID_size_dm  out  2  00 byte, 01 half, 10 word (muxed).
- ID_modifyCC  out  1  updates condition codes (muxed).
- ID_Call_instr  out  1  CALL (muxed).
- ID_B_instr  out  1  Bicc (muxed).
- ID_29_a  out  1  branch annul bit (muxed).

Behaviour:
- Memory:
  - Byte array; contents after reset are undefined; R does not clear it.
  - Write: on posedge Clk with wr_en=1, Mem[wr_addr] <= wr_data. Writes are independent of LE and S.
  - Read: if_instr = {Mem[pc], Mem[pc+1], Mem[pc+2], Mem[pc+3]}, combinational. Address arithmetic is modulo 256, so pc=255 reads bytes 255, 0, 1, 2.
- IF/ID register:
  - R=0 asynchronously clears id_instr to 0.
  - Otherwise, on posedge Clk with LE=1, id_instr <= if_instr. LE=0 holds the value.
- Decode (combinational on id_instr): op = [31:30], op2 = [24:22], op3 = [24:19]. Defaults are all zero.
  - op=01 CALL: Call_instr=1, RF_enable=1.
  - op=00, op2=010 Bicc: B_instr=1, 29_a=id_instr[29].
  - op=00, op2=100 SETHI: RF_enable=1, ALU_op3=001110.
  - op=00, any other op2 (includes all-zero word, i.e. NOP): all zero.
  - op=10, op3=111000 JMPL: jmpl_instr=1, RF_enable=1, ALU_op3=000000.
  - op=10, other op3: ALU_op3=op3, RF_enable=1, modifyCC = op3[4] & ~op3[5].
  - op=11 load/store: ALU_op3=000000 (address add).
  - size_dm from op3[1:0]: 00→10, 01→00, 10→01; 11→10.
  - op=11 with op3[2]=0 is a load: load_instr=1, RF_enable=1, SE_dm=op3[3], Read_Write=0.
  - op=11 with op3[2]=1 is a store: Read_Write=1, RF_enable=0, SE_dm=0.
- Bubble mux:
  - S=1 drives all muxed outputs to 0; ID_op is still passed through.
  - S takes effect combinationally, with no clock latency.
- Latency: an instruction at pc appears decoded one rising edge after being fetched with LE=1.
- During reset, id_instr=0, so all decoded controls are 0.

Test Plan:
- Reset/NOP: R=0 mid-cycle → id_instr=0 immediately, all controls 0; release R, preload 0 at address 0, LE=1, edge → all controls 0.
- Arithmetic: preload 0x86804002 (addcc) at address 0, pc=0, edge → ID_op=10, ALU_op3=010000, RF_enable=1, modifyCC=1; then S=1 → all muxed outputs 0, ID_op still 10.
- Load/store: ldsb word 0xC648A000 → load_instr=1, SE_dm=1, size_dm=00, RF_enable=1. stb 0xC4284000 → Read_Write=1, size_dm=00, RF_enable=0.
- Control flow:
  - CALL 0x40000004 → Call_instr=1, RF_enable=1.
  - Bicc with a=1, 0x22800002 → B_instr=1, 29_a=1.
  - JMPL 0x81C3E008 → jmpl_instr=1, ALU_op3=000000.
- Memory wrap and hold: bytes AA/BB/CC/DD at addresses 255/0/1/2, pc=255 → if_instr=0xAABBCCDD. With LE=0, clock edges leave id_instr unchanged.
